// File: rtl/pkt_deparser.sv
// Transmit-side Ethernet/IPv4/TCP deparser.
// Builds the 54-byte header from a field record, fills in the IPv4 total
// length and header checksum, then realigns the TCP payload stream behind
// the header and emits fixed-width windows to the MAC transmit path.
module pkt_deparser #(
  parameter int WIN_BYTES = 8,
  parameter int EMPTY_W   = $clog2(WIN_BYTES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hdr_valid,
  output logic                   hdr_ready,
  input  logic [47:0]            eth_dst,
  input  logic [47:0]            eth_src,
  input  logic [15:0]            ip_id,
  input  logic [7:0]             ip_ttl,
  input  logic [31:0]            ip_src,
  input  logic [31:0]            ip_dst,
  input  logic [15:0]            tcp_sport,
  input  logic [15:0]            tcp_dport,
  input  logic [31:0]            tcp_seq,
  input  logic [31:0]            tcp_ack,
  input  logic [7:0]             tcp_flags,
  input  logic [15:0]            tcp_win,
  input  logic [15:0]            pay_len,
  input  logic [WIN_BYTES*8-1:0] pay_data,
  input  logic                   pay_valid,
  input  logic                   pay_sop,
  input  logic                   pay_eop,
  input  logic [EMPTY_W-1:0]     pay_empty,
  output logic                   pay_ready,
  output logic [WIN_BYTES*8-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_W-1:0]     out_empty,
  input  logic                   out_ready,
  output logic                   err_len
);

  localparam int WB = WIN_BYTES * 8;     // window width in bits
  localparam int HB = 54 * 8;            // header width in bits
  localparam int R  = 54 % WIN_BYTES;    // header tail bytes carried into the payload beats
  localparam int H  = 54 / WIN_BYTES;    // full header beats
  localparam int RB = R * 8;
  localparam int CW = EMPTY_W + 2;       // holds R + V, which can reach 2*WIN_BYTES-1
  localparam int CSUM_MSB = HB - 1 - 8 * 24;

  typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_PAY, S_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [HB-1:0]   hdr_q, hdr_d;
  logic [RB-1:0]   res_q, res_d;
  logic [15:0]     len_q, len_d;
  logic [3:0]      beat_q, beat_d;
  logic [16:0]     cnt_q, cnt_d;
  logic [EMPTY_W-1:0] rem_q, rem_d;
  logic            err_pend_q, err_pend_d;
  logic [WB-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic            err_len_q, err_len_d;

  logic            load;
  logic [31:0]     csum_acc;
  logic [15:0]     csum;
  logic [CW-1:0]   pay_v, pay_total;
  logic [16:0]     pay_sum;
  logic            pay_mismatch;
  logic            unused_sop;

  // Framing start is implied by the header handshake; pay_sop carries no state.
  assign unused_sop = pay_sop;

  assign load      = !out_valid_q || out_ready;
  assign hdr_ready = reset && (state_q == S_IDLE);
  assign pay_ready = (state_q == S_PAY) && load;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign err_len   = err_len_q;

  // IPv4 header checksum over the ten words at bytes 14..33 (checksum slot still zero).
  always_comb begin
    csum_acc = '0;
    for (int i = 0; i < 10; i++) begin
      csum_acc = csum_acc + 32'(hdr_q[HB-1-8*(14+2*i) -: 16]);
    end
    csum_acc = {16'h0, csum_acc[15:0]} + {16'h0, csum_acc[31:16]};
    csum_acc = {16'h0, csum_acc[15:0]} + {16'h0, csum_acc[31:16]};
    csum     = ~csum_acc[15:0];
  end

  // Byte accounting for the current payload beat.
  always_comb begin
    pay_v        = pay_eop ? CW'(WIN_BYTES) - CW'(pay_empty) : CW'(WIN_BYTES);
    pay_total    = CW'(R) + pay_v;
    pay_sum      = cnt_q + 17'(pay_v);
    pay_mismatch = (pay_sum != {1'b0, len_q});
  end

  // Next-state and output-register load logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    hdr_d       = hdr_q;
    res_d       = res_q;
    len_d       = len_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    err_pend_d  = err_pend_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    err_len_d   = 1'b0;

    // A free output register drains to idle unless a state below refills it.
    if (load) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_empty_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hdr_valid) begin
          hdr_d = {eth_dst, eth_src, 16'h0800,
                   8'h45, 8'h00, (pay_len + 16'd40), ip_id, 16'h4000,
                   ip_ttl, 8'h06, 16'h0000, ip_src, ip_dst,
                   tcp_sport, tcp_dport, tcp_seq, tcp_ack,
                   8'h50, tcp_flags, tcp_win, 16'h0000, 16'h0000};
          len_d   = pay_len;
          beat_d  = '0;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        hdr_d[CSUM_MSB -: 16] = csum;
        state_d = S_HDR;
      end
      S_HDR: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_q[HB-1 -: WB];
          out_sop_d   = (beat_q == '0);
          hdr_d       = hdr_q << WB;
          beat_d      = beat_q + 4'd1;
          if (beat_q == 4'(H - 1)) begin
            res_d      = hdr_q[HB-1-WB -: RB];
            cnt_d      = '0;
            err_pend_d = 1'b0;
            if (len_q == '0) begin
              rem_d   = EMPTY_W'(R);
              state_d = S_FLUSH;
            end else begin
              state_d = S_PAY;
            end
          end
        end
      end
      S_PAY: begin
        if (load && pay_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = {res_q, pay_data[WB-1 -: WB-RB]};
          res_d       = pay_data[RB-1:0];
          cnt_d       = pay_sum;
          if (pay_eop) begin
            if (pay_total <= CW'(WIN_BYTES)) begin
              out_eop_d   = 1'b1;
              out_empty_d = EMPTY_W'(CW'(WIN_BYTES) - pay_total);
              err_len_d   = pay_mismatch;
              state_d     = S_IDLE;
            end else begin
              rem_d      = EMPTY_W'(pay_total - CW'(WIN_BYTES));
              err_pend_d = pay_mismatch;
              state_d    = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = {res_q, {(WB-RB){1'b0}}};
          out_eop_d   = 1'b1;
          out_empty_d = EMPTY_W'(WIN_BYTES) - rem_q;
          err_len_d   = err_pend_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      err_pend_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      err_pend_q  <= err_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      err_len_q   <= err_len_d;
    end
  end

  // Header, residual and declared-length datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always written by IDLE/HDR before they are read.
    hdr_q <= hdr_d;
    res_q <= res_d;
    len_q <= len_d;
  end

endmodule

// File: tb/tb_pkt_deparser.sv
// Directed self-checking bench for pkt_deparser at WIN_BYTES=8.
// A negedge monitor records accepted output beats; each test task drives
// a scenario and compares the reassembled frame with a byte-level model.
module tb_pkt_deparser;

  localparam int W  = 8;
  localparam int EW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           hdr_valid = 1'b0;
  logic           hdr_ready;
  logic [47:0]    eth_dst, eth_src;
  logic [15:0]    ip_id;
  logic [7:0]     ip_ttl;
  logic [31:0]    ip_src, ip_dst;
  logic [15:0]    tcp_sport, tcp_dport;
  logic [31:0]    tcp_seq, tcp_ack;
  logic [7:0]     tcp_flags;
  logic [15:0]    tcp_win;
  logic [15:0]    pay_len;
  logic [W*8-1:0] pay_data = '0;
  logic           pay_valid = 1'b0, pay_sop = 1'b0, pay_eop = 1'b0;
  logic [EW-1:0]  pay_empty = '0;
  logic           pay_ready;
  logic [W*8-1:0] out_data;
  logic           out_valid, out_sop, out_eop;
  logic [EW-1:0]  out_empty;
  logic           out_ready;
  logic           err_len;

  always #5 clk = ~clk;

  pkt_deparser #(.WIN_BYTES(W), .EMPTY_W(EW)) dut (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .eth_dst(eth_dst), .eth_src(eth_src), .ip_id(ip_id), .ip_ttl(ip_ttl),
    .ip_src(ip_src), .ip_dst(ip_dst), .tcp_sport(tcp_sport), .tcp_dport(tcp_dport),
    .tcp_seq(tcp_seq), .tcp_ack(tcp_ack), .tcp_flags(tcp_flags), .tcp_win(tcp_win),
    .pay_len(pay_len), .pay_data(pay_data), .pay_valid(pay_valid), .pay_sop(pay_sop),
    .pay_eop(pay_eop), .pay_empty(pay_empty), .pay_ready(pay_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready), .err_len(err_len)
  );

  typedef struct {
    logic [W*8-1:0] data;
    logic           sop;
    logic           eop;
    logic [EW-1:0]  empty;
  } beat_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  beat_t       beats[$];
  logic [7:0]  exp_q[$], got_q[$], pay_bytes[$];
  int          got_beats, got_last_empty, got_timeout, got_sop_first, got_sop_extra;
  int          stall_viol = 0, err_cycles = 0, err_bad = 0, pr_seen = 0;
  bit          toggle_ready = 1'b0;

  // Downstream ready: constant 1 or toggling each cycle, changed just after the edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_ready ? ~out_ready : 1'b1;
    end
  end

  // Monitor: capture accepted beats, stall stability, err_len alignment, pay_ready activity.
  logic           prev_stall = 1'b0;
  logic [W*8-1:0] s_data;
  logic           s_sop, s_eop;
  logic [EW-1:0]  s_empty;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== s_data || out_sop !== s_sop ||
                         out_eop !== s_eop || out_empty !== s_empty))
        stall_viol++;
      prev_stall = out_valid && !out_ready;
      s_data = out_data; s_sop = out_sop; s_eop = out_eop; s_empty = out_empty;
      if (out_valid && out_ready) beats.push_back('{out_data, out_sop, out_eop, out_empty});
      if (err_len) begin
        err_cycles++;
        if (!(out_valid && out_eop)) err_bad++;
      end
      if (pay_ready) pr_seen++;
    end
  end

  task automatic set_fields(input logic [15:0] len);
    eth_dst = 48'h001122334455;  eth_src = 48'h66778899aabb;
    ip_id = 16'h1c46;  ip_ttl = 8'h40;
    ip_src = 32'hac100a63;  ip_dst = 32'hac100a0c;
    tcp_sport = 16'h1234;  tcp_dport = 16'h0050;
    tcp_seq = 32'hdeadbeef;  tcp_ack = 32'h01020304;
    tcp_flags = 8'h18;  tcp_win = 16'hfaf0;
    pay_len = len;
  endtask

  task automatic fill_payload(input int n, input int seed);
    pay_bytes.delete();
    for (int i = 0; i < n; i++) pay_bytes.push_back(8'(seed + i * 37 + (i >> 3)));
  endtask

  task automatic push16(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  // Reference frame: header from the current fields plus the bytes actually supplied.
  task automatic build_expected(input int nsent);
    logic [31:0] s;
    logic [15:0] ck;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(eth_dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(eth_src[47-8*i -: 8]);
    push16(16'h0800);  push16(16'h4500);  push16(16'd40 + pay_len);  push16(ip_id);
    push16(16'h4000);  push16({ip_ttl, 8'h06});  push16(16'h0000);
    push16(ip_src[31:16]);  push16(ip_src[15:0]);  push16(ip_dst[31:16]);  push16(ip_dst[15:0]);
    push16(tcp_sport);  push16(tcp_dport);
    push16(tcp_seq[31:16]);  push16(tcp_seq[15:0]);  push16(tcp_ack[31:16]);  push16(tcp_ack[15:0]);
    push16({8'h50, tcp_flags});  push16(tcp_win);  push16(16'h0000);  push16(16'h0000);
    s = 0;
    for (int i = 14; i < 34; i += 2) s = s + {16'h0, exp_q[i], exp_q[i+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    ck = ~s[15:0];
    exp_q[24] = ck[15:8];
    exp_q[25] = ck[7:0];
    for (int i = 0; i < nsent; i++) exp_q.push_back(pay_bytes[i]);
  endtask

  function automatic int first_diff();
    int n;
    n = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (exp_q.size() != got_q.size()) return n;
    return -1;
  endfunction

  task automatic send_hdr();
    int cyc = 0;
    @(negedge clk);
    hdr_valid = 1'b1;
    while (!hdr_ready && cyc < 500) begin @(negedge clk); cyc++; end
    if (!hdr_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL hdr_handshake: hdr_ready stayed 0 for %0d cycles, required 1", cyc);
      hdr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 hdr_valid = 1'b0;
  endtask

  task automatic send_pay(input int n, input int max_beats, input bit gapped);
    int nb;
    int cyc;
    nb = (n + W - 1) / W;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      if (gapped && (b % 3 == 1)) @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < W; k++)
        pay_data[W*8-1-8*k -: 8] = (b*W + k < n) ? pay_bytes[b*W + k] : 8'h00;
      pay_sop   = (b == 0);
      pay_eop   = (b == nb - 1);
      pay_empty = (b == nb - 1) ? EW'(nb * W - n) : '0;
      pay_valid = 1'b1;
      cyc = 0;
      while (!pay_ready && cyc < 500) begin @(negedge clk); cyc++; end
      if (!pay_ready) begin
        tests_run++; tests_failed++;
        $display("FAIL pay_handshake: pay_ready stayed 0 for %0d cycles at beat %0d, required 1", cyc, b);
        pay_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 pay_valid = 1'b0;
    end
  endtask

  // Gather beats up to the next eop into got_q; records beat count and framing.
  task automatic collect_packet();
    beat_t b;
    int    cyc = 0;
    bit    done = 1'b0;
    got_q.delete();
    got_beats = 0; got_last_empty = -1; got_timeout = 0;
    got_sop_first = 0; got_sop_extra = 0;
    while (!done && cyc < 3000) begin
      if (beats.size() > 0) begin
        b = beats.pop_front();
        if (got_beats == 0) got_sop_first = b.sop;
        else if (b.sop) got_sop_extra++;
        for (int k = 0; k < (b.eop ? W - int'(b.empty) : W); k++) got_q.push_back(b.data[W*8-1-8*k -: 8]);
        got_beats++;
        if (b.eop) begin done = 1'b1; got_last_empty = int'(b.empty); end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) got_timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests_run++; if ({out_sop, out_eop, out_empty} !== '0) begin tests_failed++; $display("FAIL reset_framing: got %b, required 0", {out_sop, out_eop, out_empty}); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL reset_err_len: got %b, required 0", err_len); end
    tests_run++; if (hdr_ready !== 1'b0 || pay_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got hdr=%b pay=%b, required 0 0", hdr_ready, pay_ready); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (hdr_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_hdr_ready: got %b, required 1", hdr_ready); end
  endtask

  task automatic test_zero_len();
    int d;
    set_fields(16'd0);
    pr_seen = 0;
    send_hdr();
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_t0: out_valid got %b, required 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_t1: out_valid got %b, required 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_sop !== 1'b1) begin tests_failed++; $display("FAIL latency_t2: valid/sop got %b%b, required 11", out_valid, out_sop); end
    collect_packet();
    build_expected(0);
    d = first_diff();
    tests_run++; if (got_timeout != 0) begin tests_failed++; $display("FAIL zero_eop: no eop seen, required one"); end
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL zero_bytes: first diff at byte %0d, got size %0d, required size %0d", d, got_q.size(), exp_q.size()); end
    tests_run++; if (got_beats != 7 || got_last_empty != 2) begin tests_failed++; $display("FAIL zero_beats: got %0d beats empty %0d, required 7 beats empty 2", got_beats, got_last_empty); end
    tests_run++; if (got_sop_first != 1 || got_sop_extra != 0) begin tests_failed++; $display("FAIL zero_sop: got first=%0d extra=%0d, required 1 0", got_sop_first, got_sop_extra); end
    tests_run++; if (got_q[12] !== 8'h08 || got_q[13] !== 8'h00) begin tests_failed++; $display("FAIL zero_ethertype: got %h%h, required 0800", got_q[12], got_q[13]); end
    tests_run++; if (pr_seen != 0) begin tests_failed++; $display("FAIL zero_pay_ready: asserted %0d cycles, required 0", pr_seen); end
  endtask

  task automatic test_checksum();
    logic [7:0] ipv [20];
    int d;
    ipv = '{8'h45, 8'h00, 8'h00, 8'h3c, 8'h1c, 8'h46, 8'h40, 8'h00, 8'h40, 8'h06,
            8'hb1, 8'he6, 8'hac, 8'h10, 8'h0a, 8'h63, 8'hac, 8'h10, 8'h0a, 8'h0c};
    set_fields(16'd20);
    fill_payload(20, 3);
    send_hdr();
    send_pay(20, 99, 1'b0);
    collect_packet();
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (got_q[14+i] !== ipv[i]) begin tests_failed++; $display("FAIL csum_ip_byte%0d: got %h, required %h", 14+i, got_q[14+i], ipv[i]); end
    end
    build_expected(20);
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL csum_frame: first diff at byte %0d, got size %0d, required size %0d", d, got_q.size(), exp_q.size()); end
    tests_run++; if (got_beats != 10 || got_last_empty != 6) begin tests_failed++; $display("FAIL csum_beats: got %0d beats empty %0d, required 10 beats empty 6", got_beats, got_last_empty); end
  endtask

  task automatic test_short();
    int lens [2] = '{2, 3};
    int nbt  [2] = '{7, 8};
    int emp  [2] = '{0, 7};
    int d;
    for (int c = 0; c < 2; c++) begin
      set_fields(16'(lens[c]));
      fill_payload(lens[c], 50 + c);
      send_hdr();
      send_pay(lens[c], 99, 1'b0);
      collect_packet();
      build_expected(lens[c]);
      d = first_diff();
      tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL short%0d_bytes: first diff at byte %0d, got size %0d, required size %0d", lens[c], d, got_q.size(), exp_q.size()); end
      tests_run++; if (got_beats != nbt[c] || got_last_empty != emp[c]) begin tests_failed++; $display("FAIL short%0d_beats: got %0d beats empty %0d, required %0d beats empty %0d", lens[c], got_beats, got_last_empty, nbt[c], emp[c]); end
    end
  endtask

  task automatic test_stall();
    int d;
    stall_viol = 0;
    toggle_ready = 1'b1;
    set_fields(16'd100);
    fill_payload(100, 9);
    send_hdr();
    send_pay(100, 99, 1'b1);
    collect_packet();
    toggle_ready = 1'b0;
    build_expected(100);
    d = first_diff();
    tests_run++; if (got_q.size() != 154) begin tests_failed++; $display("FAIL stall_size: got %0d bytes, required 154", got_q.size()); end
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL stall_bytes: first diff at byte %0d", d); end
    tests_run++; if (got_beats != 20 || got_last_empty != 6) begin tests_failed++; $display("FAIL stall_beats: got %0d beats empty %0d, required 20 beats empty 6", got_beats, got_last_empty); end
    tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL stall_stable: %0d unstable stall cycles, required 0", stall_viol); end
  endtask

  task automatic test_len_err();
    int d;
    err_cycles = 0; err_bad = 0;
    set_fields(16'd20);
    fill_payload(16, 77);
    send_hdr();
    send_pay(16, 99, 1'b0);
    collect_packet();
    repeat (2) @(negedge clk);
    build_expected(16);
    d = first_diff();
    tests_run++; if (got_q.size() != 70 || d >= 0) begin tests_failed++; $display("FAIL lenerr_bytes: got size %0d first diff %0d, required size 70 no diff", got_q.size(), d); end
    tests_run++; if (got_beats != 9 || got_last_empty != 2) begin tests_failed++; $display("FAIL lenerr_beats: got %0d beats empty %0d, required 9 beats empty 2", got_beats, got_last_empty); end
    tests_run++; if (err_cycles != 1) begin tests_failed++; $display("FAIL lenerr_pulse: err_len high %0d cycles, required 1", err_cycles); end
    tests_run++; if (err_bad != 0) begin tests_failed++; $display("FAIL lenerr_align: %0d err_len cycles off the eop beat, required 0", err_bad); end
    tests_run++; if (got_q[16] !== 8'h00 || got_q[17] !== 8'h3c) begin tests_failed++; $display("FAIL lenerr_iplen: got %h%h, required 003c", got_q[16], got_q[17]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a[$];
    int eops = 0;
    int d;
    err_cycles = 0;
    set_fields(16'd100);
    fill_payload(100, 21);
    send_hdr();
    send_pay(100, 3, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (out_valid !== 1'b0 || hdr_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_reset: valid=%b hdr_ready=%b, required 0 0", out_valid, hdr_ready); end
    reset = 1'b1;
    @(negedge clk);
    foreach (beats[i]) if (beats[i].eop) eops++;
    tests_run++; if (eops != 0) begin tests_failed++; $display("FAIL abort_no_eop: got %0d eop beats, required 0", eops); end
    beats.delete();
    // Packet A then packet B, B's header offered as soon as A finishes.
    set_fields(16'd5);
    fill_payload(5, 120);
    build_expected(5);
    exp_a = exp_q;
    send_hdr();
    send_pay(5, 99, 1'b0);
    set_fields(16'd13);
    tcp_seq = 32'h00000100;
    fill_payload(13, 200);
    send_hdr();
    send_pay(13, 99, 1'b0);
    collect_packet();
    exp_q = exp_a;
    d = first_diff();
    tests_run++; if (d >= 0 || got_timeout != 0) begin tests_failed++; $display("FAIL b2b_a_bytes: first diff at %0d size %0d, required size 59", d, got_q.size()); end
    tests_run++; if (got_sop_first != 1 || got_sop_extra != 0 || got_beats != 8) begin tests_failed++; $display("FAIL b2b_a_frame: sop=%0d extra=%0d beats=%0d, required 1 0 8", got_sop_first, got_sop_extra, got_beats); end
    collect_packet();
    build_expected(13);
    d = first_diff();
    tests_run++; if (d >= 0 || got_timeout != 0) begin tests_failed++; $display("FAIL b2b_b_bytes: first diff at %0d size %0d, required size 67", d, got_q.size()); end
    tests_run++; if (got_sop_first != 1 || got_sop_extra != 0 || got_beats != 9 || got_last_empty != 5) begin tests_failed++; $display("FAIL b2b_b_frame: sop=%0d extra=%0d beats=%0d empty=%0d, required 1 0 9 5", got_sop_first, got_sop_extra, got_beats, got_last_empty); end
    tests_run++; if (err_cycles != 0) begin tests_failed++; $display("FAIL b2b_err_len: high %0d cycles, required 0", err_cycles); end
  endtask

  initial begin
    set_fields(16'd0);
    test_reset();
    test_zero_len();
    test_checksum();
    test_short();
    test_stall();
    test_len_err();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_deparser.md
Name: pkt_deparser

Overview:
- Transmit-side counterpart of the Ethernet/IPv4/TCP parser.
- Takes a header-field record and a TCP payload window stream, and emits a framed Ethernet packet stream in fixed-width windows, ready for the MAC transmit path.
- Builds the 14-byte Ethernet, 20-byte IPv4 (no options) and 20-byte TCP (no options) headers, computes IPv4 total length and header checksum, and realigns the payload behind the 54-byte header.
- The TCP checksum is written as 0x0000; a downstream offload fills it.

Parameters:
WIN_BYTES, 8, bytes per stream beat; legal values 4, 8, 16, 32.
EMPTY_W, $clog2(WIN_BYTES), width of the empty-byte count.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
hdr_valid  in  1  header record valid
hdr_ready  out  1  header record accepted when hdr_valid && hdr_ready
eth_dst, eth_src  in  48 each  MAC addresses
ip_id  in  16  IPv4 identification
ip_ttl  in  8  IPv4 TTL
ip_src, ip_dst  in  32 each  IPv4 addresses
tcp_sport, tcp_dport  in  16 each  TCP ports
tcp_seq, tcp_ack  in  32 each  sequence / ack numbers
tcp_flags  in  8  TCP flag byte
tcp_win  in  16  TCP window
pay_len  in  16  declared payload bytes (0..1460)
pay_data  in  WIN_BYTES*8  payload window; byte 0 in MSBs
pay_valid, pay_sop, pay_eop  in  1 each  payload framing
pay_empty  in  EMPTY_W  unused trailing bytes on the eop beat
pay_ready  out  1  payload beat accepted when pay_valid && pay_ready
out_data  out  WIN_BYTES*8  Ethernet window; byte 0 in MSBs
out_valid, out_sop, out_eop  out  1 each  output framing
out_empty  out  EMPTY_W  unused trailing bytes on the eop beat
out_ready  in  1  downstream accepts when out_valid && out_ready
err_len  out  1  one-cycle pulse: received payload bytes != pay_len

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. When reset=0 at a clk edge:
  - all outputs go to 0 except hdr_ready=0 and pay_ready=0;
  - state goes to IDLE and any partial packet is discarded (no eop emitted).
- Fixed header fields:
  - ethertype 0x0800; version/IHL 0x45; TOS 0x00; flags/frag 0x4000; protocol 0x06.
  - TCP data offset byte 0x50; urgent pointer 0x0000; TCP checksum 0x0000.
- IPv4 total length = 40 + pay_len, 16-bit.
- IPv4 checksum:
  - one's-complement sum of the ten header 16-bit words, with the checksum word taken as 0;
  - fold carries twice, then invert.
- Output stage: one output register. It loads when !out_valid || out_ready. While out_valid=1 && out_ready=0, out_* hold stable.
- R = 54 mod WIN_BYTES (6 for WIN_BYTES=8). H = number of full header beats = floor(54/WIN_BYTES).
- States:
  - IDLE: hdr_ready=1. On hdr accept, latch all fields → CSUM.
  - CSUM: one cycle computing the checksum → HDR. hdr_ready=0.
  - HDR: emit H full header beats; the first has out_sop=1.
    - If pay_len==0: emit a final beat holding the R tail bytes with out_eop=1, out_empty=WIN_BYTES-R → IDLE.
    - Else: hold the R tail bytes in the residual register → PAY.
  - PAY: pay_ready = output register can load.
    - Each beat emits {residual R bytes, first WIN_BYTES-R payload bytes}; the residual becomes the last R payload bytes.
    - On the pay_eop beat, V = WIN_BYTES - pay_empty and total = R + V.
      - total ≤ WIN_BYTES: emit with out_eop=1, out_empty=WIN_BYTES-total → IDLE.
      - otherwise: emit a full beat, then → FLUSH.
  - FLUSH: emit the remaining total-WIN_BYTES bytes with out_eop=1 and out_empty to match → IDLE.
- pay_ready=0 outside PAY. Payload presented early is held off, not dropped. pay_sop is informational only.
- Latency: hdr accepted at edge T → first out_valid at T+2 when out_ready=1.
- Length check: a byte counter runs over PAY.
  - At pay_eop, if counter ≠ pay_len, err_len pulses for exactly one cycle, coincident with the final out_eop beat.
  - The packet is still emitted as received; the IP length stays as declared.
- Zero-length payload: no payload beats are consumed.

Test Plan:
- Checksum, WIN_BYTES=8: ip_src=172.16.10.99, ip_dst=172.16.10.12, ip_id=0x1c46, ip_ttl=64, pay_len=20 → IPv4 header bytes 45 00 00 3c 1c 46 40 00 40 06 b1 e6 ac 10 0a 63 ac 10 0a 0c at out bytes 14..33.
- pay_len=0 → 7 beats: sop on beat 0, eop on beat 6, out_empty=2, ethertype 08 00 at bytes 12..13; no pay_ready assertion.
- pay_len=2 (one beat, pay_empty=6) → 7 beats, last beat out_empty=0; pay_len=3 (pay_empty=5) → 8 beats, last beat out_empty=7 (FLUSH path).
- pay_len=100 with out_ready toggling every cycle and pay_valid gapped → 154-byte stream identical to the golden model; out_* stable while stalled.
- pay_len=20 but 16 bytes supplied (second beat eop, pay_empty=0) → err_len high for exactly one cycle with the out_eop beat; output is 70 bytes.
- reset=0 asserted during PAY beat 3, then two back-to-back packets → no eop for the aborted packet; both subsequent packets are correct with sop/eop paired.
